reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised power-up sequencer that releases NUM_UNITS downstream blocks from reset one at a time, then asserts a run enable. It is the next-generation replacement for the fixed five-stage controller. Stage durations are run-time programmable. Each stage can advance either on a timer or on a done handshake from its unit, with a timeout. It also supports start, abort and restart control. It sits at the top level between the board reset and the memory, PE, pooling and display blocks.

## Interface
- NUM_UNITS, 4: number of sequenced units; N below. Must be ≥ 1.
- CNT_W, 32: width of the stage counter and of each stage_time field.
- AUTO_START, 1: if 1, IDLE leaves automatically after reset; if 0, IDLE waits for start.
- SW, $clog2(NUM_UNITS+4): state output width (derived, localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; begins the sequence from IDLE, DONE or ERROR.
- abort  in  1  synchronous; forces IDLE from any state.
- stage_time  in  (N+1)*CNT_W  field k = bits [k*CNT_W +: CNT_W] is the duration/timeout for stage k (k = 0..N).
- wait_done  in  N  bit k-1 = 1 puts stage k (k ≥ 1) in done mode.
- unit_done  in  N  bit k-1 = done handshake from unit k-1.
- unit_rst  out  N  active-high reset to each unit.
- run  out  1  high in DONE only (replaces the display enable).
- busy  out  1  high in any STAGE state.
- err  out  1  high in ERROR.
- err_stage  out  SW  index k of the stage that timed out.
- state  out  SW  encoding: 0 = IDLE, k+1 = STAGE k, N+2 = DONE, N+3 = ERROR.

## Operation
- Reset values: state = IDLE, counter = 0, unit_rst = all 1, run = 0, busy = 0, err = 0, err_stage = 0, latched times = 0.
- Outputs are registered and change on the same edge as state.
  - unit_rst[j] = 0 iff state ∈ STAGE k with k > j, or state = DONE.
  - IDLE, STAGE 0 and ERROR: all unit_rst = 1.
- IDLE → STAGE 0 on start = 1, or unconditionally when AUTO_START = 1. On this transition stage_time is latched into internal registers. Later changes to stage_time have no effect until the next start.
- STAGE 0 is always timed.
- Timed stage k: counter increments each cycle. When counter ≥ T[k], go to the next stage (STAGE k+1, or DONE after STAGE N) and clear counter. The stage therefore lasts T[k]+1 cycles; T[k] = 0 gives 1 cycle.
- Done-mode stage k (k ≥ 1, wait_done[k-1] = 1):
  - unit_done[k-1] = 1 → advance on the next edge and clear counter.
  - Else counter ≥ T[k] → ERROR; err_stage = k.
  - done and timeout in the same cycle → done wins.
  - wait_done is sampled live, not latched.
- DONE: holds, with run = 1 and all unit_rst = 0.
- ERROR: holds, with all unit_rst = 1 and err = 1.
- start in DONE or ERROR → STAGE 0, relatching stage_time. err and err_stage clear on leaving ERROR.
- start while busy → ignored.
- abort = 1 in any state → IDLE next edge; counter = 0; err and err_stage clear.
  - abort overrides start and AUTO_START in the same cycle.
  - With AUTO_START = 1, the sequence restarts once abort drops.
- Counter saturates at all-ones and never wraps.
- Asserting rst mid-sequence forces the reset values immediately (asynchronously).

## Timing
- First cycle after rst deasserts (AUTO_START = 1): IDLE. One edge later: STAGE 0.
- Total timed sequence length from entering STAGE 0 to DONE = sum over k of (T[k]+1) cycles.
- unit_rst[k-1] falls on the same edge state becomes STAGE k.
- Done-mode latency: unit_done high at edge e → new state visible after edge e.
- abort latency: 1 edge.

## Test plan
- N=4, AUTO_START=1, T = {3,2,5,1,0}, wait_done = 0 → STAGE 0 for 4 cycles, then unit_rst releases 0001, 0011, 0111, 1111 after 3/6/2/1 cycles. DONE (run = 1) is reached 16 edges after entering STAGE 0.
- wait_done = 0010, T[2] = 10, unit_done[1] pulsed on the 4th cycle of STAGE 2 → advance to STAGE 3 on that edge, err = 0.
- wait_done = 0010, T[2] = 10, unit_done held 0 → ERROR after 11 cycles in STAGE 2. Check err = 1, err_stage = 2, unit_rst = 1111, run = 0. A start pulse then → STAGE 0 and err = 0.
- unit_done[1] and timeout in the same cycle (counter = T[2]) → advance to STAGE 3, no ERROR.
- abort during STAGE 3 → IDLE next edge with unit_rst = 1111. With AUTO_START = 0, a start pulse in the same cycle as abort is ignored and the block stays in IDLE. The next start → STAGE 0.
- stage_time changed mid-sequence → durations unchanged until the next start. Async rst in STAGE 2 → all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: releases NUM_UNITS blocks from reset one stage at a time,
// then raises run. Each stage advances on a programmable timer or a unit done handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start (or leaving at once when AUTO_START = 1)
// ST_STAGE | sequencing stage stage_q; units with index < stage_q released
// ST_DONE  | every unit released, run high
// ST_ERROR | a done-mode stage timed out; every unit held in reset
module reset_sequencer #(
    parameter int NUM_UNITS  = 4,
    parameter int CNT_W      = 32,
    parameter int AUTO_START = 1,
    localparam int SW        = $clog2(NUM_UNITS + 4)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [(NUM_UNITS+1)*CNT_W-1:0] stage_time,
    input  logic [NUM_UNITS-1:0]           wait_done,
    input  logic [NUM_UNITS-1:0]           unit_done,
    output logic [NUM_UNITS-1:0]           unit_rst,
    output logic                           run,
    output logic                           busy,
    output logic                           err,
    output logic [SW-1:0]                  err_stage,
    output logic [SW-1:0]                  state
);

    localparam int TW = (NUM_UNITS + 1) * CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STAGE,
        ST_DONE,
        ST_ERROR
    } fsm_t;

    fsm_t                 fsm_q, fsm_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]        times_q, times_d;
    logic [NUM_UNITS-1:0] unit_rst_q, unit_rst_d;
    logic                 run_q, run_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [SW-1:0]        err_stage_q, err_stage_d;
    logic [SW-1:0]        state_q, state_d;

    logic [CNT_W-1:0]     cur_time;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 cur_wait;
    logic                 cur_udone;
    logic                 timeout;
    logic                 last_stage;

    // Per-stage selection of latched duration and live handshake controls.
    always_comb begin
        cur_time  = '0;
        cur_wait  = 1'b0;
        cur_udone = 1'b0;
        for (int k = 0; k <= NUM_UNITS; k++) begin
            if (stage_q == SW'(k)) begin
                cur_time = times_q[k*CNT_W +: CNT_W];
            end
        end
        for (int k = 1; k <= NUM_UNITS; k++) begin
            if (stage_q == SW'(k)) begin
                cur_wait  = wait_done[k-1];
                cur_udone = unit_done[k-1];
            end
        end
    end

    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout    = (cnt_q >= cur_time);
    assign last_stage = (stage_q == SW'(NUM_UNITS));

    always_comb begin
        fsm_d       = fsm_q;
        stage_d     = stage_q;
        cnt_d       = cnt_q;
        times_d     = times_q;
        err_stage_d = err_stage_q;

        if (abort) begin
            fsm_d       = ST_IDLE;
            stage_d     = '0;
            cnt_d       = '0;
            err_stage_d = '0;
        end else begin
            case (fsm_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start || (fsm_q == ST_IDLE && AUTO_START != 0)) begin
                        fsm_d       = ST_STAGE;
                        stage_d     = '0;
                        cnt_d       = '0;
                        times_d     = stage_time;
                        err_stage_d = '0;
                    end
                end
                ST_STAGE: begin
                    // In done mode the handshake has priority over the timeout.
                    if ((cur_wait && cur_udone) || (!cur_wait && timeout)) begin
                        cnt_d = '0;
                        if (last_stage) begin
                            fsm_d = ST_DONE;
                        end else begin
                            stage_d = stage_q + SW'(1);
                        end
                    end else if (cur_wait && timeout) begin
                        fsm_d       = ST_ERROR;
                        cnt_d       = '0;
                        err_stage_d = stage_q;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    fsm_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so they change on the same edge.
    always_comb begin
        unit_rst_d = '1;
        for (int j = 0; j < NUM_UNITS; j++) begin
            if ((fsm_d == ST_STAGE && stage_d > SW'(j)) || fsm_d == ST_DONE) begin
                unit_rst_d[j] = 1'b0;
            end
        end
        run_d  = (fsm_d == ST_DONE);
        busy_d = (fsm_d == ST_STAGE);
        err_d  = (fsm_d == ST_ERROR);
        case (fsm_d)
            ST_IDLE:  state_d = '0;
            ST_STAGE: state_d = stage_d + SW'(1);
            ST_DONE:  state_d = SW'(NUM_UNITS + 2);
            default:  state_d = SW'(NUM_UNITS + 3);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= ST_IDLE;
            stage_q     <= '0;
            cnt_q       <= '0;
            times_q     <= '0;
            unit_rst_q  <= '1;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
            state_q     <= '0;
        end else begin
            fsm_q       <= fsm_d;
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            times_q     <= times_d;
            unit_rst_q  <= unit_rst_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            state_q     <= state_d;
        end
    end

    assign unit_rst  = unit_rst_q;
    assign run       = run_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign err_stage = err_stage_q;
    assign state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: one auto-start and one manual-start instance,
// expected observations queued as stimulus is driven and compared after each edge.
module tb_reset_sequencer;

    localparam int N      = 4;
    localparam int CW     = 8;
    localparam int SW     = 3;
    localparam int C_IDLE = 0;
    localparam int C_DONE = N + 2;
    localparam int C_ERR  = N + 3;

    typedef struct packed {
        logic [SW-1:0] st;
        logic [N-1:0]  ur;
        logic          run;
        logic          busy;
        logic          err;
        logic [SW-1:0] es;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [(N+1)*CW-1:0] stage_time;
    logic [N-1:0]      wait_done;
    logic [N-1:0]      unit_done;

    logic [N-1:0]  unit_rst_a, unit_rst_m;
    logic          run_a, run_m, busy_a, busy_m, err_a, err_m;
    logic [SW-1:0] err_stage_a, err_stage_m, state_a, state_m;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t sb_q[$];

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_UNITS(N), .CNT_W(CW), .AUTO_START(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .stage_time(stage_time), .wait_done(wait_done), .unit_done(unit_done),
        .unit_rst(unit_rst_a), .run(run_a), .busy(busy_a), .err(err_a),
        .err_stage(err_stage_a), .state(state_a)
    );

    reset_sequencer #(.NUM_UNITS(N), .CNT_W(CW), .AUTO_START(0)) dut_m (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .stage_time(stage_time), .wait_done(wait_done), .unit_done(unit_done),
        .unit_rst(unit_rst_m), .run(run_m), .busy(busy_m), .err(err_m),
        .err_stage(err_stage_m), .state(state_m)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [(N+1)*CW-1:0] pack_t(input int t0, input int t1, input int t2,
                                                   input int t3, input int t4);
        return {CW'(t4), CW'(t3), CW'(t2), CW'(t1), CW'(t0)};
    endfunction

    // Expected outputs for a state code: IDLE 0, STAGE k -> k+1, DONE N+2, ERROR N+3.
    function automatic obs_t ex(input int code, input int es);
        obs_t          e;
        logic [N-1:0]  all1;
        all1 = '1;
        e    = '0;
        e.st = SW'(code);
        if (code == C_IDLE || code == C_ERR) begin
            e.ur = all1;
        end else if (code == C_DONE) begin
            e.ur  = '0;
            e.run = 1'b1;
        end else begin
            e.ur   = all1 << (code - 1);
            e.busy = 1'b1;
        end
        if (code == C_ERR) begin
            e.err = 1'b1;
            e.es  = SW'(es);
        end
        return e;
    endfunction

    function automatic obs_t grab(input bit sel_m);
        obs_t o;
        if (sel_m) o = {state_m, unit_rst_m, run_m, busy_m, err_m, err_stage_m};
        else       o = {state_a, unit_rst_a, run_a, busy_a, err_a, err_stage_a};
        return o;
    endfunction

    task automatic compare(input string tag, input bit sel_m);
        obs_t e, o;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(0), 32'(1));
        end else begin
            e = sb_q.pop_front();
            o = grab(sel_m);
            chk({tag, ".state"},     32'(o.st),   32'(e.st));
            chk({tag, ".unit_rst"},  32'(o.ur),   32'(e.ur));
            chk({tag, ".run"},       32'(o.run),  32'(e.run));
            chk({tag, ".busy"},      32'(o.busy), 32'(e.busy));
            chk({tag, ".err"},       32'(o.err),  32'(e.err));
            chk({tag, ".err_stage"}, 32'(o.es),   32'(e.es));
        end
    endtask

    task automatic step(input string tag, input bit sel_m, input int code, input int es = 0);
        sb_q.push_back(ex(code, es));
        @(posedge clk);
        #1;
        compare(tag, sel_m);
    endtask

    task automatic stay(input string tag, input bit sel_m, input int code, input int n);
        for (int i = 0; i < n; i++) step(tag, sel_m, code);
    endtask

    task automatic do_reset;
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        wait_done = '0;
        unit_done = '0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(ex(C_IDLE, 0));
        compare("rst_a", 1'b0);
        sb_q.push_back(ex(C_IDLE, 0));
        compare("rst_m", 1'b1);
        rst = 1'b1;
        sb_q.push_back(ex(C_IDLE, 0));
        compare("rel_a", 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stage_time = pack_t(3, 2, 5, 1, 0);
        do_reset();

        // Timed sequence; stage_time edits and a start while busy are ignored.
        step("t1_s0", 0, 1);
        stage_time = pack_t(1, 0, 0, 0, 0);
        stay("t1_s0", 0, 1, 3);
        stay("t1_s1", 0, 2, 3);
        step("t1_s2", 0, 3);
        start = 1'b1;
        step("t1_s2", 0, 3);
        start = 1'b0;
        stay("t1_s2", 0, 3, 4);
        stay("t1_s3", 0, 4, 2);
        stay("t1_s4", 0, 5, 1);
        stay("t1_done", 0, C_DONE, 2);
        start = 1'b1;
        step("t1_re_s0", 0, 1);
        start = 1'b0;
        step("t1_re_s0", 0, 1);
        step("t1_re_s1", 0, 2);
        step("t1_re_s2", 0, 3);
        step("t1_re_s3", 0, 4);
        step("t1_re_s4", 0, 5);
        step("t1_re_done", 0, C_DONE);

        // Done handshake on the 4th cycle of stage 2.
        stage_time = pack_t(0, 0, 10, 0, 0);
        do_reset();
        wait_done = 4'b0010;
        step("t2_s0", 0, 1);
        step("t2_s1", 0, 2);
        stay("t2_s2", 0, 3, 4);
        unit_done = 4'b0010;
        step("t2_s3", 0, 4);
        unit_done = '0;
        step("t2_s4", 0, 5);
        step("t2_done", 0, C_DONE);

        // Timeout in stage 2, then restart from ERROR.
        do_reset();
        wait_done = 4'b0010;
        step("t3_s0", 0, 1);
        step("t3_s1", 0, 2);
        stay("t3_s2", 0, 3, 11);
        step("t3_err", 0, C_ERR, 2);
        step("t3_err_hold", 0, C_ERR, 2);
        start = 1'b1;
        step("t3_restart", 0, 1);
        start = 1'b0;
        step("t3_re_s1", 0, 2);
        step("t3_re_s2", 0, 3);

        // Done and timeout in the same cycle: done wins.
        do_reset();
        wait_done = 4'b0010;
        step("t4_s0", 0, 1);
        step("t4_s1", 0, 2);
        stay("t4_s2", 0, 3, 11);
        unit_done = 4'b0010;
        step("t4_s3", 0, 4);
        unit_done = '0;
        step("t4_s4", 0, 5);
        step("t4_done", 0, C_DONE);

        // Abort in stage 3 with auto start: back to IDLE, then restart.
        stage_time = pack_t(1, 1, 1, 4, 1);
        do_reset();
        stay("t5a_s0", 0, 1, 2);
        stay("t5a_s1", 0, 2, 2);
        stay("t5a_s2", 0, 3, 2);
        stay("t5a_s3", 0, 4, 2);
        abort = 1'b1;
        step("t5a_abort", 0, C_IDLE);
        abort = 1'b0;
        stay("t5a_auto_s0", 0, 1, 2);
        step("t5a_auto_s1", 0, 2);

        // Manual start: abort overrides a simultaneous start.
        do_reset();
        step("t5m_idle", 1, C_IDLE);
        start = 1'b1;
        step("t5m_s0", 1, 1);
        start = 1'b0;
        step("t5m_s0", 1, 1);
        stay("t5m_s1", 1, 2, 2);
        stay("t5m_s2", 1, 3, 2);
        stay("t5m_s3", 1, 4, 2);
        abort = 1'b1;
        start = 1'b1;
        step("t5m_abort", 1, C_IDLE);
        abort = 1'b0;
        start = 1'b0;
        stay("t5m_idle_hold", 1, C_IDLE, 2);
        start = 1'b1;
        step("t5m_restart", 1, 1);
        start = 1'b0;
        step("t5m_re_s0", 1, 1);
        step("t5m_re_s1", 1, 2);

        // Asynchronous reset in stage 2 takes effect before the next edge.
        stage_time = pack_t(1, 1, 3, 1, 1);
        do_reset();
        stay("t6_s0", 0, 1, 2);
        stay("t6_s1", 0, 2, 2);
        stay("t6_s2", 0, 3, 2);
        #2;
        rst = 1'b0;
        sb_q.push_back(ex(C_IDLE, 0));
        #1;
        compare("t6_async", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
